// File: rtl/cacheline_burst_adaptor.sv
`default_nettype none
// ============================================================================
// Module  : cacheline_burst_adaptor
// Brief   : Splits one cacheline read/write into a BEATS-long burst on the
//           DRAM-side bus. Optional watchdog enabled by `define BURST_TIMEOUT_EN.
// Revision: 1.0 - initial release
// ============================================================================
module cacheline_burst_adaptor #(
  parameter int LINE_WIDTH     = 256,
  parameter int BEAT_WIDTH     = 64,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [31:0]           line_address,
  input  logic                  line_read,
  input  logic                  line_write,
  input  logic [LINE_WIDTH-1:0] line_wdata,
  output logic [LINE_WIDTH-1:0] line_rdata,
  output logic                  line_resp,
  output logic                  line_err,
  output logic [31:0]           burst_address,
  output logic                  burst_read,
  output logic                  burst_write,
  output logic [BEAT_WIDTH-1:0] burst_wdata,
  input  logic [BEAT_WIDTH-1:0] burst_rdata,
  input  logic                  burst_resp
);

  localparam int C_BEATS       = LINE_WIDTH / BEAT_WIDTH;
  localparam int C_CNT_W       = $clog2(C_BEATS);
  localparam int C_OFFSET_BITS = $clog2(LINE_WIDTH / 8);
  localparam logic [31:0]        C_ADDR_MASK = ~((32'd1 << C_OFFSET_BITS) - 32'd1);
  localparam logic [C_CNT_W-1:0] C_LAST_BEAT = C_CNT_W'(C_BEATS - 1);

  if (C_BEATS < 2 || C_BEATS * BEAT_WIDTH != LINE_WIDTH || TIMEOUT_CYCLES < 2) begin : g_param_check
    $error("cacheline_burst_adaptor: illegal LINE_WIDTH/BEAT_WIDTH/TIMEOUT_CYCLES");
  end

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RD_BURST = 2'd1,
    ST_WR_BURST = 2'd2,
    ST_DONE     = 2'd3
  } state_t;

  state_t                r_state;
  logic [C_CNT_W-1:0]    r_beat;
  logic [LINE_WIDTH-1:0] r_wdata;

`ifdef BURST_TIMEOUT_EN
  localparam int C_TMO_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [C_TMO_W-1:0] C_TMO_LAST = C_TMO_W'(TIMEOUT_CYCLES - 1);
  logic [C_TMO_W-1:0] r_tmo;
`else
  assign line_err = 1'b0;
`endif

  // Write data is shifted down one beat per acknowledge, so the current beat is always the low slice.
  assign burst_wdata = r_wdata[BEAT_WIDTH-1:0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= ST_IDLE;
      r_beat        <= '0;
      r_wdata       <= '0;
      line_rdata    <= '0;
      line_resp     <= 1'b0;
      burst_address <= '0;
      burst_read    <= 1'b0;
      burst_write   <= 1'b0;
`ifdef BURST_TIMEOUT_EN
      line_err      <= 1'b0;
      r_tmo         <= '0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_beat <= '0;
`ifdef BURST_TIMEOUT_EN
          r_tmo  <= '0;
`endif
          if (line_write) begin
            r_state       <= ST_WR_BURST;
            burst_write   <= 1'b1;
            burst_address <= line_address & C_ADDR_MASK;
            r_wdata       <= line_wdata;
          end else if (line_read) begin
            r_state       <= ST_RD_BURST;
            burst_read    <= 1'b1;
            burst_address <= line_address & C_ADDR_MASK;
          end
        end

        ST_RD_BURST, ST_WR_BURST: begin
          if (burst_resp) begin
            r_beat <= r_beat + 1'b1;
            if (r_state == ST_RD_BURST) begin
              line_rdata[BEAT_WIDTH*r_beat +: BEAT_WIDTH] <= burst_rdata;
            end else begin
              r_wdata <= r_wdata >> BEAT_WIDTH;
            end
            if (r_beat == C_LAST_BEAT) begin
              r_state     <= ST_DONE;
              burst_read  <= 1'b0;
              burst_write <= 1'b0;
              line_resp   <= 1'b1;
            end
`ifdef BURST_TIMEOUT_EN
            r_tmo <= '0;
          end else if (r_tmo == C_TMO_LAST) begin
            r_state     <= ST_DONE;
            burst_read  <= 1'b0;
            burst_write <= 1'b0;
            line_resp   <= 1'b1;
            line_err    <= 1'b1;
          end else begin
            r_tmo <= r_tmo + 1'b1;
`endif
          end
        end

        ST_DONE: begin
          r_state   <= ST_IDLE;
          line_resp <= 1'b0;
          r_wdata   <= '0;
`ifdef BURST_TIMEOUT_EN
          line_err  <= 1'b0;
`endif
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
